// File: rtl/fetch_align_if.sv
// rtl/fetch_align_if.sv - fetch-side and decode-side handshake bundle for fetch_align
interface fetch_align_if #(
   parameter int PC_WIDTH = 32
);
   logic                fetch_valid;
   logic                fetch_ready;
   logic [PC_WIDTH-1:0] fetch_addr;
   logic [31:0]         fetch_data;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_instr;
   logic [PC_WIDTH-1:0] out_pc;
   logic                out_compressed;
   logic                out_illegal;

   modport master (
      output fetch_valid, fetch_addr, fetch_data, out_ready,
      input  fetch_ready, out_valid, out_instr, out_pc, out_compressed, out_illegal
   );

   modport slave (
      input  fetch_valid, fetch_addr, fetch_data, out_ready,
      output fetch_ready, out_valid, out_instr, out_pc, out_compressed, out_illegal
   );
endinterface

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - realigns 32-bit fetch words into 16/32-bit instructions with PC
module fetch_align #(
   parameter int DEPTH    = 4,
   parameter int RVC      = 1,
   parameter int PC_WIDTH = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic [PC_WIDTH-1:0] flush_pc,
   fetch_align_if.slave        bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int AW    = PC_WIDTH - 2;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [AW-1:0]       addr_q [DEPTH];
   logic [AW-1:0]       addr_d [DEPTH];
   logic [31:0]         data_q [DEPTH];
   logic [31:0]         data_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                off_q, off_d;
   logic                valid_q, valid_d;
   logic [31:0]         instr_q, instr_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                comp_q, comp_d;
   logic                ill_q, ill_d;

   logic [31:0]         head, nxt;
   logic [PC_WIDTH-1:0] head_pc;
   logic                ext, pop, x_off, x_comp, x_ill;
   logic [31:0]         x_instr;
   logic [PC_WIDTH-1:0] x_pc;
   logic                load, push, fetch_ready;
   logic                unused_bits;

   assign unused_bits = ^{flush_pc[0], bus.fetch_addr[1:0]};
   assign fetch_ready = (count_q < DEPTH_C);

   // Extraction candidate from the head word (and the next word for a straddling 32-bit instruction)
   always_comb begin
      head    = data_q[rd_ptr_q];
      nxt     = data_q[rd_ptr_q + PTR_W'(1)];
      head_pc = {addr_q[rd_ptr_q], 2'b00};
      ext     = 1'b0;
      pop     = 1'b0;
      x_off   = off_q;
      x_instr = 32'h0;
      x_pc    = head_pc;
      x_comp  = 1'b0;
      x_ill   = 1'b0;
      if (count_q != '0) begin
         if (RVC != 0) begin
            if (!off_q) begin
               ext = 1'b1;
               if (head[1:0] != 2'b11) begin
                  x_instr = {16'h0, head[15:0]};
                  x_comp  = 1'b1;
                  x_ill   = (head[15:0] == 16'h0);
                  x_off   = 1'b1;
               end else begin
                  x_instr = head;
                  pop     = 1'b1;
               end
            end else if (head[17:16] != 2'b11) begin
               ext     = 1'b1;
               pop     = 1'b1;
               x_instr = {16'h0, head[31:16]};
               x_pc    = head_pc + PC_WIDTH'(2);
               x_comp  = 1'b1;
               x_ill   = (head[31:16] == 16'h0);
               x_off   = 1'b0;
            end else if (count_q >= CNT_W'(2)) begin
               ext     = 1'b1;
               pop     = 1'b1;
               x_instr = {nxt[15:0], head[31:16]};
               x_pc    = head_pc + PC_WIDTH'(2);
            end
         end else begin
            // Without RVC every word leaves whole; only a post-flush odd start yields a half word
            ext   = 1'b1;
            pop   = 1'b1;
            x_off = 1'b0;
            if (off_q) begin
               x_instr = {16'h0, head[31:16]};
               x_pc    = head_pc + PC_WIDTH'(2);
               x_ill   = 1'b1;
            end else begin
               x_instr = head;
               x_ill   = (head[1:0] != 2'b11);
            end
         end
      end
   end

   always_comb begin
      load     = (!valid_q || bus.out_ready) && ext;
      push     = bus.fetch_valid && fetch_ready && !flush;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      off_d    = off_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      comp_d   = comp_q;
      ill_d    = ill_q;
      if (push) begin
         addr_d[wr_ptr_q] = bus.fetch_addr[PC_WIDTH-1:2];
         data_d[wr_ptr_q] = bus.fetch_data;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (load && pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(load && pop);
      if (load) begin
         off_d   = x_off;
         valid_d = 1'b1;
         instr_d = x_instr;
         pc_d    = x_pc;
         comp_d  = x_comp;
         ill_d   = x_ill;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         off_d    = flush_pc[1];
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         off_q    <= 1'b0;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         pc_q     <= '0;
         comp_q   <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         off_q    <= off_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         comp_q   <= comp_d;
         ill_q    <= ill_d;
      end
   end

   assign bus.fetch_ready    = fetch_ready;
   assign bus.out_valid      = valid_q;
   assign bus.out_instr      = instr_q;
   assign bus.out_pc         = pc_q;
   assign bus.out_compressed = comp_q;
   assign bus.out_illegal    = ill_q;
endmodule

// File: tb/tb_fetch_align.sv
// tb/tb_fetch_align.sv - self-checking bench for fetch_align (RVC and non-RVC instances)
module tb_fetch_align;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        c;
      logic        ill;
   } rec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] w0;
      logic [31:0] w1;
      int          nw;
      int          ne;
      rec_t [2:0]  e;
   } case_t;

   localparam int NR = 200;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        flush0 = 1'b0, flush1 = 1'b0;
   logic [31:0] fpc0 = '0, fpc1 = '0;
   int          checks = 0, errors = 0;
   rec_t        got0[$], got1[$], exp0[$], exp1[$];
   rec_t        last0, last1;
   bit          hold0 = 0, hold1 = 0;
   case_t       tab[4];
   logic [31:0] rw[NR];

   always #5 clock = ~clock;

   fetch_align_if #(.PC_WIDTH(32)) if0 ();
   fetch_align_if #(.PC_WIDTH(32)) if1 ();

   fetch_align #(.DEPTH(4), .RVC(1), .PC_WIDTH(32)) u0 (
      .clock(clock), .reset(reset), .flush(flush0), .flush_pc(fpc0), .bus(if0));
   fetch_align #(.DEPTH(4), .RVC(0), .PC_WIDTH(32)) u1 (
      .clock(clock), .reset(reset), .flush(flush1), .flush_pc(fpc1), .bus(if1));

   function automatic rec_t rec(logic [31:0] i, logic [31:0] p, logic c, logic l);
      rec_t r;
      r.instr = i; r.pc = p; r.c = c; r.ill = l;
      return r;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Accepted outputs are logged; held outputs must not change under backpressure
   always @(negedge clock) begin
      if (!reset || flush0) hold0 = 0;
      else begin
         if (hold0) begin
            chk("hold0_valid", if0.out_valid, 1);
            chk("hold0_instr", if0.out_instr, last0.instr);
            chk("hold0_pc", if0.out_pc, last0.pc);
         end
         if (if0.out_valid && if0.out_ready)
            got0.push_back(rec(if0.out_instr, if0.out_pc, if0.out_compressed, if0.out_illegal));
         hold0 = if0.out_valid && !if0.out_ready;
         last0 = rec(if0.out_instr, if0.out_pc, if0.out_compressed, if0.out_illegal);
      end
   end

   always @(negedge clock) begin
      if (!reset || flush1) hold1 = 0;
      else begin
         if (hold1) begin
            chk("hold1_valid", if1.out_valid, 1);
            chk("hold1_instr", if1.out_instr, last1.instr);
            chk("hold1_pc", if1.out_pc, last1.pc);
         end
         if (if1.out_valid && if1.out_ready)
            got1.push_back(rec(if1.out_instr, if1.out_pc, if1.out_compressed, if1.out_illegal));
         hold1 = if1.out_valid && !if1.out_ready;
         last1 = rec(if1.out_instr, if1.out_pc, if1.out_compressed, if1.out_illegal);
      end
   end

   task automatic do_flush(int inst, logic [31:0] pc);
      if (inst == 0) begin flush0 = 1; fpc0 = pc; end
      else begin flush1 = 1; fpc1 = pc; end
      step();
      flush0 = 0;
      flush1 = 0;
      if (inst == 0) got0.delete(); else got1.delete();
   endtask

   task automatic pushw(int inst, logic [31:0] a, logic [31:0] d, bit rnd);
      int b = 0;
      if (inst == 0) begin if0.fetch_valid = 1; if0.fetch_addr = a; if0.fetch_data = d; end
      else begin if1.fetch_valid = 1; if1.fetch_addr = a; if1.fetch_data = d; end
      while (!(inst == 0 ? if0.fetch_ready : if1.fetch_ready)) begin
         if (rnd) begin
            if (inst == 0) if0.out_ready = 1'($urandom_range(1));
            else if1.out_ready = 1'($urandom_range(1));
         end
         step();
         b++;
         if (b > 100) begin chk("push_timeout", 0, 1); break; end
      end
      if (rnd) begin
         if (inst == 0) if0.out_ready = 1'($urandom_range(1));
         else if1.out_ready = 1'($urandom_range(1));
      end
      step();
      if (inst == 0) if0.fetch_valid = 0; else if1.fetch_valid = 0;
   endtask

   task automatic wait_got(int inst, int n);
      int b = 0;
      while ((inst == 0 ? got0.size() : got1.size()) < n && b < 400) begin
         step();
         b++;
      end
      chk($sformatf("wait_out%0d", inst), (inst == 0 ? got0.size() : got1.size()) >= n, 1);
   endtask

   task automatic cmp(int inst, string n, rec_t e, bit chk_c);
      rec_t g;
      if (inst == 0 && got0.size() > 0) g = got0.pop_front();
      else if (inst == 1 && got1.size() > 0) g = got1.pop_front();
      else begin chk({n, "_missing"}, 0, 1); return; end
      chk({n, "_instr"}, g.instr, e.instr);
      chk({n, "_pc"}, g.pc, e.pc);
      if (chk_c) chk({n, "_comp"}, g.c, e.c);
      chk({n, "_ill"}, g.ill, e.ill);
   endtask

   initial begin
      logic [15:0] hq[$];
      logic [31:0] aq[$];
      int          acc;

      if0.fetch_valid = 0; if0.fetch_addr = '0; if0.fetch_data = '0; if0.out_ready = 0;
      if1.fetch_valid = 0; if1.fetch_addr = '0; if1.fetch_data = '0; if1.out_ready = 0;
      #1;
      chk("rst_valid", if0.out_valid, 0);
      chk("rst_instr", if0.out_instr, 0);
      chk("rst_pc", if0.out_pc, 0);
      chk("rst_comp", if0.out_compressed, 0);
      chk("rst_ill", if0.out_illegal, 0);
      chk("rst_fready", if0.fetch_ready, 1);
      chk("rst1_valid", if1.out_valid, 0);
      chk("rst1_fready", if1.fetch_ready, 1);
      step();
      reset = 1;
      step();

      tab[0] = '{addr: 32'h100, w0: 32'h00000013, w1: 32'h00100093, nw: 2, ne: 2, e: '0};
      tab[0].e[0] = rec(32'h00000013, 32'h100, 0, 0);
      tab[0].e[1] = rec(32'h00100093, 32'h104, 0, 0);
      tab[1] = '{addr: 32'h200, w0: 32'h45014505, w1: 32'h0, nw: 1, ne: 2, e: '0};
      tab[1].e[0] = rec(32'h00004505, 32'h200, 1, 0);
      tab[1].e[1] = rec(32'h00004501, 32'h202, 1, 0);
      tab[2] = '{addr: 32'h300, w0: 32'h00134505, w1: 32'h00000000, nw: 2, ne: 3, e: '0};
      tab[2].e[0] = rec(32'h00004505, 32'h300, 1, 0);
      tab[2].e[1] = rec(32'h00000013, 32'h302, 0, 0);
      tab[2].e[2] = rec(32'h00000000, 32'h306, 1, 1);
      tab[3] = '{addr: 32'h600, w0: 32'h00000001, w1: 32'h0, nw: 1, ne: 2, e: '0};
      tab[3].e[0] = rec(32'h00000001, 32'h600, 1, 0);
      tab[3].e[1] = rec(32'h00000000, 32'h602, 1, 1);

      for (int t = 0; t < 4; t++) begin
         do_flush(0, tab[t].addr);
         if0.out_ready = 1;
         pushw(0, tab[t].addr, tab[t].w0, 0);
         if (tab[t].nw > 1) pushw(0, tab[t].addr + 4, tab[t].w1, 0);
         wait_got(0, tab[t].ne);
         repeat (4) step();
         chk($sformatf("t%0d_count", t), got0.size(), tab[t].ne);
         chk($sformatf("t%0d_idle", t), if0.out_valid, 0);
         for (int k = 0; k < tab[t].ne; k++) cmp(0, $sformatf("t%0d_o%0d", t, k), tab[t].e[k], 1);
      end

      // A straddling instruction must wait for its second word
      do_flush(0, 32'h300);
      pushw(0, 32'h300, 32'h00134505, 0);
      repeat (5) step();
      chk("straddle_wait", got0.size(), 1);
      pushw(0, 32'h304, 32'h00000000, 0);
      wait_got(0, 3);
      cmp(0, "strad_a", rec(32'h4505, 32'h300, 1, 0), 1);
      cmp(0, "strad_b", rec(32'h13, 32'h302, 0, 0), 1);

      // Backpressure until full, then drain in order
      do_flush(0, 32'h700);
      if0.out_ready = 0;
      acc = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if0.fetch_valid = (acc < 6);
         if0.fetch_addr  = 32'h700 + 32'(4 * acc);
         if0.fetch_data  = 32'h00000013 + (32'(acc) << 20);
         if (if0.fetch_valid && if0.fetch_ready) begin step(); acc++; end
         else step();
      end
      if0.fetch_valid = 0;
      chk("full_accepts", acc, 5);
      chk("full_fready", if0.fetch_ready, 0);
      chk("full_valid", if0.out_valid, 1);
      chk("full_instr", if0.out_instr, 32'h00000013);
      chk("full_pc", if0.out_pc, 32'h700);
      if0.out_ready = 1;
      pushw(0, 32'h714, 32'h00500013, 0);
      wait_got(0, 6);
      for (int k = 0; k < 6; k++)
         cmp(0, $sformatf("drain%0d", k), rec(32'h00000013 + (32'(k) << 20), 32'h700 + 32'(4 * k), 0, 0), 1);

      // Flush with output valid and words queued
      do_flush(0, 32'h800);
      if0.out_ready = 0;
      for (int k = 0; k < 4; k++) pushw(0, 32'h800 + 32'(4 * k), 32'h00000013, 0);
      step();
      chk("pre_flush_valid", if0.out_valid, 1);
      do_flush(0, 32'h402);
      chk("flush_valid", if0.out_valid, 0);
      chk("flush_fready", if0.fetch_ready, 1);
      repeat (3) step();
      chk("flush_empty", if0.out_valid, 0);
      if0.out_ready = 1;
      pushw(0, 32'h400, 32'h00004505, 0);
      wait_got(0, 1);
      cmp(0, "flush_out", rec(32'h0, 32'h402, 1, 1), 1);

      // Non-RVC instance
      do_flush(1, 32'h500);
      if1.out_ready = 1;
      pushw(1, 32'h500, 32'h00004505, 0);
      wait_got(1, 1);
      repeat (3) step();
      chk("nrvc_count", got1.size(), 1);
      chk("nrvc_idle", if1.out_valid, 0);
      cmp(1, "nrvc", rec(32'h00004505, 32'h500, 0, 1), 1);
      do_flush(1, 32'h502);
      pushw(1, 32'h500, 32'h00134505, 0);
      pushw(1, 32'h504, 32'h00000013, 0);
      wait_got(1, 2);
      cmp(1, "nrvc_odd", rec(32'h00000013, 32'h502, 0, 1), 0);
      cmp(1, "nrvc_next", rec(32'h00000013, 32'h504, 0, 0), 1);

      // Randomized streams against a halfword-stream model
      for (int k = 0; k < NR; k++) begin
         logic [15:0] lo, hi;
         lo = 16'($urandom); hi = 16'($urandom);
         if ($urandom_range(1) == 1) lo[1:0] = 2'b11;
         if ($urandom_range(1) == 1) hi[1:0] = 2'b11;
         if ($urandom_range(15) == 0) lo = 16'h0;
         if ($urandom_range(15) == 0) hi = 16'h0;
         rw[k] = {hi, lo};
      end
      exp0.delete();
      exp1.delete();
      for (int k = 0; k < NR; k++) begin
         hq.push_back(rw[k][15:0]);  aq.push_back(32'h1000 + 32'(4 * k));
         hq.push_back(rw[k][31:16]); aq.push_back(32'h1002 + 32'(4 * k));
         exp1.push_back(rec(rw[k], 32'h1000 + 32'(4 * k), 0, rw[k][1:0] != 2'b11));
      end
      void'(hq.pop_front());
      void'(aq.pop_front());
      while (hq.size() > 0) begin
         if (hq[0][1:0] != 2'b11) begin
            exp0.push_back(rec({16'h0, hq[0]}, aq[0], 1, hq[0] == 16'h0));
            void'(hq.pop_front()); void'(aq.pop_front());
         end else if (hq.size() >= 2) begin
            exp0.push_back(rec({hq[1], hq[0]}, aq[0], 0, 0));
            void'(hq.pop_front()); void'(aq.pop_front());
            void'(hq.pop_front()); void'(aq.pop_front());
         end else break;
      end
      do_flush(0, 32'h1002);
      do_flush(1, 32'h1000);
      fork
         begin
            for (int k = 0; k < NR; k++) begin
               while ($urandom_range(3) == 0) begin if0.out_ready = 1'($urandom_range(1)); step(); end
               pushw(0, 32'h1000 + 32'(4 * k), rw[k], 1);
            end
            if0.out_ready = 1;
            wait_got(0, exp0.size());
         end
         begin
            for (int k = 0; k < NR; k++) begin
               while ($urandom_range(3) == 0) begin if1.out_ready = 1'($urandom_range(1)); step(); end
               pushw(1, 32'h1000 + 32'(4 * k), rw[k], 1);
            end
            if1.out_ready = 1;
            wait_got(1, exp1.size());
         end
      join
      repeat (5) step();
      chk("rand0_count", got0.size(), exp0.size());
      chk("rand1_count", got1.size(), exp1.size());
      for (int i = 0; i < exp0.size(); i++) cmp(0, $sformatf("rand0_%0d", i), exp0[i], 1);
      for (int i = 0; i < exp1.size(); i++) cmp(1, $sformatf("rand1_%0d", i), exp1[i], 1);

      // Asynchronous reset while an output is held
      do_flush(1, 32'h900);
      if1.out_ready = 0;
      pushw(1, 32'h900, 32'h00000013, 0);
      step();
      step();
      chk("pre_rst_valid", if1.out_valid, 1);
      #2;
      reset = 0;
      #1;
      chk("arst_valid", if1.out_valid, 0);
      chk("arst_instr", if1.out_instr, 0);
      chk("arst_pc", if1.out_pc, 0);
      chk("arst_fready", if1.fetch_ready, 1);
      step();
      reset = 1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
